// File: rtl/dice_cgra_dispatcher.sv
// Thread dispatcher: issues one linear tid per cycle with its 3-D coordinates into the CGRA,
// then waits for the pipe to empty, flushes it and reports block completion.
module dice_cgra_dispatcher #(
  parameter int unsigned NUM_TID   = 512,
  parameter int unsigned TID_WIDTH = $clog2(NUM_TID)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TID_WIDTH-1:0] ntid_x,
  input  logic [TID_WIDTH-1:0] ntid_y,
  input  logic [TID_WIDTH-1:0] ntid_z,
  input  logic [NUM_TID-1:0]   active_mask,
  input  logic                 cgra_done,
  output logic                 busy,
  output logic [TID_WIDTH-1:0] disp_tid,
  output logic                 disp_valid,
  output logic [TID_WIDTH-1:0] tid_x,
  output logic [TID_WIDTH-1:0] tid_y,
  output logic [TID_WIDTH-1:0] tid_z,
  output logic                 clr,
  output logic                 block_done
);

  localparam int unsigned PW = 3 * TID_WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [TID_WIDTH-1:0]   lin_q, lin_d;
  logic [TID_WIDTH-1:0]   x_q, x_d;
  logic [TID_WIDTH-1:0]   y_q, y_d;
  logic [TID_WIDTH-1:0]   z_q, z_d;
  logic [TID_WIDTH-1:0]   last_q, last_d;
  logic [TID_WIDTH-1:0]   ntx_q, ntx_d;
  logic [TID_WIDTH-1:0]   nty_q, nty_d;
  logic [NUM_TID-1:0]     mask_q, mask_d;
  logic                   guard_q, guard_d;

  logic [PW-1:0]          prod;
  logic                   prod_zero;
  logic [TID_WIDTH-1:0]   n_last;
  logic                   x_wrap;
  logic                   y_wrap;
  logic                   issuing;

  // Full-width product so oversized blocks clamp instead of wrapping.
  always_comb begin
    prod      = PW'(ntid_x) * PW'(ntid_y) * PW'(ntid_z);
    prod_zero = (prod == '0);
    if (prod > PW'(NUM_TID)) begin
      n_last = TID_WIDTH'(NUM_TID - 1);
    end else begin
      n_last = prod[TID_WIDTH-1:0] - TID_WIDTH'(1);
    end
  end

  assign x_wrap = (x_q == ntx_q - TID_WIDTH'(1));
  assign y_wrap = (y_q == nty_q - TID_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    lin_d   = lin_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    last_d  = last_q;
    ntx_d   = ntx_q;
    nty_d   = nty_q;
    mask_d  = mask_q;
    guard_d = guard_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ntx_d   = ntid_x;
          nty_d   = ntid_y;
          mask_d  = active_mask;
          last_d  = n_last;
          lin_d   = '0;
          x_d     = '0;
          y_d     = '0;
          z_d     = '0;
          guard_d = 1'b0;
          state_d = prod_zero ? StFlush : StIssue;
        end
      end
      StIssue: begin
        if (lin_q == last_q) begin
          lin_d   = '0;
          x_d     = '0;
          y_d     = '0;
          z_d     = '0;
          guard_d = 1'b0;
          state_d = StDrain;
        end else begin
          lin_d = lin_q + TID_WIDTH'(1);
          if (x_wrap) begin
            x_d = '0;
            if (y_wrap) begin
              y_d = '0;
              z_d = z_q + TID_WIDTH'(1);
            end else begin
              y_d = y_q + TID_WIDTH'(1);
            end
          end else begin
            x_d = x_q + TID_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        // cgra_done lags the last issue by one register; ignore it for one cycle.
        if (!guard_q) begin
          guard_d = 1'b1;
        end else if (cgra_done) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lin_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      last_q  <= '0;
      ntx_q   <= '0;
      nty_q   <= '0;
      mask_q  <= '0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lin_q   <= lin_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      last_q  <= last_d;
      ntx_q   <= ntx_d;
      nty_q   <= nty_d;
      mask_q  <= mask_d;
      guard_q <= guard_d;
    end
  end

  assign issuing    = (state_q == StIssue);
  assign busy       = (state_q != StIdle);
  assign disp_valid = issuing & mask_q[lin_q];
  assign disp_tid   = issuing ? lin_q : '0;
  assign tid_x      = issuing ? x_q : '0;
  assign tid_y      = issuing ? y_q : '0;
  assign tid_z      = issuing ? z_q : '0;
  assign clr        = (state_q == StFlush);
  assign block_done = (state_q == StFlush);

endmodule

// File: doc/dice_cgra_dispatcher.md
# dice_cgra_dispatcher

- Issues one thread ID per cycle into the CGRA subsystem (`disp_tid`/`disp_valid`), together with the matching 3-D `tid_x/y/z`.
- Skips threads that are inactive in a mask latched at launch.
- After the last issue, waits for the subsystem's `done` (pipe empty), pulses `clr`, then reports block completion.
- Sits between the thread-block scheduler and the CGRA subsystem.

## Interface
Parameters:
- `NUM_TID`, 512: max threads per block.
- `TID_WIDTH`, `$clog2(NUM_TID)`: tid and dimension width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch request; one-cycle pulse, honoured only in IDLE.
- `ntid_x`, `ntid_y`, `ntid_z` in `TID_WIDTH` each: block dimensions; sampled on accepted `start`.
- `active_mask` in `NUM_TID`: per-tid active bits; sampled on accepted `start`.
- `cgra_done` in 1: subsystem pipe-empty indication.
- `busy` out 1: high in any state other than IDLE.
- `disp_tid` out `TID_WIDTH`: current linear tid.
- `disp_valid` out 1: `disp_tid` is an issued, active thread.
- `tid_x`, `tid_y`, `tid_z` out `TID_WIDTH` each: coordinates of `disp_tid`.
- `clr` out 1: one-cycle subsystem flush pulse.
- `block_done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE, `start`=1:
  - Latch dims and mask.
  - Compute `N = ntid_x*ntid_y*ntid_z` at `3*TID_WIDTH` bits; clamp N to `NUM_TID`.
  - If N=0 (any dimension zero), go to FLUSH.
  - Otherwise clear the counters (lin, x, y, z) and go to ISSUE.
- ISSUE, every cycle:
  - Outputs: `disp_tid` = lin, `tid_*` = x/y/z, `disp_valid` = `mask_q[lin]`.
  - Inactive tids produce a bubble cycle; no compaction.
  - Counter step: lin+1; x+1; on x = `ntid_x`-1, x wraps to 0 and y+1; on y = `ntid_y`-1, y wraps to 0 and z+1.
  - When lin = N-1: go to DRAIN with the guard counter = 0.
  - Counters are never divided; coordinates are always consistent with lin.
- DRAIN:
  - One guard cycle is mandatory (the subsystem's `done` lags the last `disp_valid` by one register).
  - Thereafter, `cgra_done`=1 moves to FLUSH.
  - No timeout.
- FLUSH: `clr`=1 and `block_done`=1 for exactly this cycle, then IDLE.
- `start` while `busy`=1 is ignored (not queued).
- Outside ISSUE: `disp_valid`=0; `disp_tid` and `tid_*` are held at 0.

## Timing
- Reset values: state IDLE, `busy`=0, `disp_valid`=0, `disp_tid`=0, `tid_*`=0, `clr`=0, `block_done`=0, mask register = 0.
- `start` sampled at edge T: `busy`=1 and tid 0 presented in cycle T+1.
- Tid k is presented in cycle T+1+k; ISSUE lasts exactly N cycles.
- `disp_valid`, `busy`, `clr` and `block_done` are decoded from registered state and latched mask only; there is no combinational path from any input.
- With `cgra_done` already high: last issue in cycle L, DRAIN guard in L+1, DRAIN sees `cgra_done` in L+2, FLUSH in L+3, IDLE in L+4.
- N=0 path: FLUSH in T+1, IDLE in T+2.
- A new `start` can be accepted in the first IDLE cycle after FLUSH.
- `rst_n` asserted mid-operation: all outputs take reset values immediately (asynchronously); no `clr` or `block_done` is emitted.
- N > `NUM_TID`: issue stops at tid `NUM_TID`-1; coordinates remain wrap-consistent.

## Test plan
- 2x2x1 dims, mask `0xF`, `cgra_done` tied 1:
  - tids 0..3 valid in T+1..T+4.
  - (x,y) sequence (0,0), (1,0), (0,1), (1,1).
  - `clr` and `block_done` in T+7.
- 4x1x1 dims, mask `0b1010`:
  - valid only on tids 1 and 3; tids 0 and 2 are bubbles with `disp_valid`=0.
  - ISSUE lasts 4 cycles.
- 3x2x2 dims, `cgra_done` held 0 for 5 cycles after the last issue:
  - `busy` stays 1 and no `clr` until `cgra_done` rises.
  - `tid_z` toggles to 1 at tid 6.
- `ntid_y`=0: no `disp_valid`; `clr` and `block_done` in T+1.
- Second `start` during ISSUE: ignored; exactly one `block_done`; the tid sequence is unchanged.
- `rst_n` low at tid 5 of a 16-thread block: all outputs 0 immediately. A subsequent `start` restarts at tid 0.
- 32x32x1 dims (product 1024, `NUM_TID`=512): exactly 512 issue cycles; last tid 511 with (x,y)=(31,15).
